// File: rtl/beam_phase_scheduler.sv
// Beam phase scheduler: walks an N_COLS x N_ROWS element grid, runs phase_calc once per element
// and stores the calibrated 6-bit phase codes in a registered-read phase table.
module beam_phase_scheduler #(
   parameter int unsigned  N_COLS  = 4,
   parameter int unsigned  N_ROWS  = 4,
   parameter logic [15:0]  PITCH_X = 16'd1920,
   parameter logic [15:0]  PITCH_Y = 16'd1920,
   parameter int unsigned  TIMEOUT = 255,
   localparam int unsigned N_ELEM  = N_COLS * N_ROWS,
   localparam int unsigned ADDR_W  = $clog2(N_ELEM)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_is_tx,
   input  logic [15:0]       cmd_az,
   input  logic [15:0]       cmd_el,
   output logic              calc_start,
   output logic              calc_is_tx,
   output logic [15:0]       calc_x,
   output logic [15:0]       calc_y,
   output logic [15:0]       calc_az,
   output logic [15:0]       calc_el,
   input  logic              calc_busy,
   input  logic              calc_valid,
   input  logic [5:0]        calc_idx,
   input  logic              cal_we,
   input  logic [ADDR_W-1:0] cal_addr,
   input  logic [5:0]        cal_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [5:0]        rd_data,
   output logic              busy,
   output logic              done,
   output logic              err_timeout
);

   localparam int unsigned       CNT_W      = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  TimeoutCnt = CNT_W'(TIMEOUT);
   localparam logic [ADDR_W-1:0] LastAddr   = ADDR_W'(N_ELEM - 1);
   localparam logic [ADDR_W-1:0] LastCol    = ADDR_W'(N_COLS - 1);

   typedef enum logic [2:0] {StIdle, StIssue, StWait, StWrite, StDone} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] col_q, col_d;
   logic [15:0]       x_acc_q, x_acc_d;
   logic [15:0]       y_acc_q, y_acc_d;
   logic [15:0]       az_q, az_d;
   logic [15:0]       el_q, el_d;
   logic              is_tx_q, is_tx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [5:0]        idx_q, idx_d;
   logic              err_q, err_d;
   logic              tbl_we;
   logic [5:0]        tbl_wdata;
   logic [5:0]        rd_data_q;
   logic [5:0]        tbl_q [N_ELEM];
   logic [5:0]        cal_q [N_ELEM];

   // Calibrated code wraps mod 64; cal is read before any same-edge cal write lands.
   assign tbl_wdata = idx_q + cal_q[addr_q];

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      col_d      = col_q;
      x_acc_d    = x_acc_q;
      y_acc_d    = y_acc_q;
      az_d       = az_q;
      el_d       = el_q;
      is_tx_d    = is_tx_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      err_d      = err_q;
      calc_start = 1'b0;
      tbl_we     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               state_d = StIssue;
               is_tx_d = cmd_is_tx;
               az_d    = cmd_az;
               el_d    = cmd_el;
               addr_d  = '0;
               col_d   = '0;
               x_acc_d = '0;
               y_acc_d = '0;
               err_d   = 1'b0;
            end
         end
         StIssue: begin
            if (!calc_busy) begin
               calc_start = 1'b1;
               cnt_d      = '0;
               state_d    = StWait;
            end
         end
         StWait: begin
            if (calc_valid) begin
               idx_d   = calc_idx;
               state_d = StWrite;
            end else if (cnt_q == TimeoutCnt) begin
               err_d   = 1'b1;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StWrite: begin
            tbl_we  = 1'b1;
            state_d = (addr_q == LastAddr) ? StDone : StIssue;
            addr_d  = addr_q + ADDR_W'(1);
            // Row advance by accumulation keeps the datapath multiplier-free.
            if (col_q == LastCol) begin
               col_d   = '0;
               x_acc_d = '0;
               y_acc_d = y_acc_q + PITCH_Y;
            end else begin
               col_d   = col_q + ADDR_W'(1);
               x_acc_d = x_acc_q + PITCH_X;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         addr_q  <= '0;
         col_q   <= '0;
         x_acc_q <= '0;
         y_acc_q <= '0;
         az_q    <= '0;
         el_q    <= '0;
         is_tx_q <= 1'b0;
         cnt_q   <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         col_q   <= col_d;
         x_acc_q <= x_acc_d;
         y_acc_q <= y_acc_d;
         az_q    <= az_d;
         el_q    <= el_d;
         is_tx_q <= is_tx_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   // Registered read samples the table before a same-edge write (read-before-write).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N_ELEM; i++) begin
            tbl_q[i] <= '0;
            cal_q[i] <= '0;
         end
         rd_data_q <= '0;
      end else begin
         rd_data_q <= tbl_q[rd_addr];
         if (tbl_we) begin
            tbl_q[addr_q] <= tbl_wdata;
         end
         if (cal_we) begin
            cal_q[cal_addr] <= cal_data;
         end
      end
   end

   assign cmd_ready   = (state_q == StIdle);
   assign busy        = (state_q != StIdle);
   assign done        = (state_q == StDone);
   assign err_timeout = err_q;
   assign calc_is_tx  = is_tx_q;
   assign calc_az     = az_q;
   assign calc_el     = el_q;
   assign calc_x      = x_acc_q;
   assign calc_y      = y_acc_q;
   assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_beam_phase_scheduler.sv
// Bench for beam_phase_scheduler: 2x2 grid, phase_calc stub, timeline reference model
// compared every cycle, plus literal expectations for the directed scenarios.
module tb_beam_phase_scheduler;

   localparam int NC    = 2;
   localparam int NE    = 4;
   localparam int TO    = 16;
   localparam int PITCH = 1920;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_is_tx = 1'b0;
   logic [15:0] cmd_az = '0;
   logic [15:0] cmd_el = '0;
   logic        calc_start, calc_is_tx;
   logic [15:0] calc_x, calc_y, calc_az, calc_el;
   logic        calc_busy = 1'b0;
   logic        calc_valid = 1'b0;
   logic [5:0]  calc_idx = '0;
   logic        cal_we = 1'b0;
   logic [1:0]  cal_addr = '0;
   logic [5:0]  cal_data = '0;
   logic [1:0]  rd_addr = '0;
   logic [5:0]  rd_data;
   logic        busy, done, err_timeout;

   beam_phase_scheduler #(
      .N_COLS (2),
      .N_ROWS (2),
      .PITCH_X(16'd1920),
      .PITCH_Y(16'd1920),
      .TIMEOUT(16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_is_tx  (cmd_is_tx),
      .cmd_az     (cmd_az),
      .cmd_el     (cmd_el),
      .calc_start (calc_start),
      .calc_is_tx (calc_is_tx),
      .calc_x     (calc_x),
      .calc_y     (calc_y),
      .calc_az    (calc_az),
      .calc_el    (calc_el),
      .calc_busy  (calc_busy),
      .calc_valid (calc_valid),
      .calc_idx   (calc_idx),
      .cal_we     (cal_we),
      .cal_addr   (cal_addr),
      .cal_data   (cal_data),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .busy       (busy),
      .done       (done),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   function automatic logic [15:0] elem_x(input int e);
      return 16'((e % NC) * PITCH);
   endfunction

   function automatic logic [15:0] elem_y(input int e);
      return 16'((e / NC) * PITCH);
   endfunction

   // ---------------- reference model (timeline of one scan) ----------------
   bit          m_active, m_started, m_got, m_err, m_tx;
   int          m_elem, m_issue_from, m_start_cyc, m_write_cyc, m_done_cyc;
   logic [5:0]  m_idx, m_rd;
   logic [15:0] m_az, m_el;
   logic [5:0]  m_tbl [NE];
   logic [5:0]  m_cal [NE];
   int          m_acc_cnt = 0, m_acc_cyc = 0, m_done_cnt = 0;
   bit          e_ready, e_start, e_done;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_active = 0; m_started = 0; m_got = 0; m_err = 0; m_tx = 0;
         m_az = '0; m_el = '0; m_rd = '0;
         m_write_cyc = -1; m_done_cyc = -1;
         for (int i = 0; i < NE; i++) begin
            m_tbl[i] = '0;
            m_cal[i] = '0;
         end
         check("reset_status", {75'd0, cmd_ready, busy, calc_start, done, err_timeout},
               {75'd0, 5'b10000});
         check("reset_operands", {15'd0, calc_is_tx, calc_x, calc_y, calc_az, calc_el}, '0);
         check("reset_rd_data", {74'd0, rd_data}, '0);
      end else begin
         e_ready = !m_active;
         e_start = m_active && !m_started && cyc >= m_issue_from && !calc_busy;
         e_done  = m_active && cyc == m_done_cyc;
         check("status{ready,busy,start,done,err}",
               {75'd0, cmd_ready, busy, calc_start, done, err_timeout},
               {75'd0, e_ready, m_active, e_start, e_done, m_err});
         check("operands{tx,az,el}", {47'd0, calc_is_tx, calc_az, calc_el},
               {47'd0, m_tx, m_az, m_el});
         if (m_active && !e_done)
            check("calc_xy", {48'd0, calc_x, calc_y}, {48'd0, elem_x(m_elem), elem_y(m_elem)});
         check("rd_data", {74'd0, rd_data}, {74'd0, m_rd});
         // state for the next cycle
         m_rd = m_tbl[rd_addr];
         if (m_active) begin
            if (e_start) begin
               m_started   = 1;
               m_start_cyc = cyc;
            end else if (m_started && !m_got && m_done_cyc < 0) begin
               if (calc_valid) begin
                  m_got       = 1;
                  m_idx       = calc_idx;
                  m_write_cyc = cyc + 1;
               end else if (cyc == m_start_cyc + 1 + TO) begin
                  m_done_cyc = cyc + 1;
                  m_err      = 1;
               end
            end
            if (cyc == m_write_cyc) begin
               m_tbl[m_elem] = m_idx + m_cal[m_elem];
               if (m_elem == NE - 1) begin
                  m_done_cyc = cyc + 1;
               end else begin
                  m_elem++;
                  m_issue_from = cyc + 1;
                  m_started    = 0;
                  m_got        = 0;
               end
            end
            if (e_done) begin
               m_active = 0;
               m_done_cnt++;
            end
         end
         if (cal_we) m_cal[cal_addr] = cal_data;
         if (e_ready && cmd_valid) begin
            m_active = 1; m_issue_from = cyc + 1; m_elem = 0;
            m_started = 0; m_got = 0; m_write_cyc = -1; m_done_cyc = -1; m_err = 0;
            m_tx = cmd_is_tx; m_az = cmd_az; m_el = cmd_el;
            m_acc_cnt++;
            m_acc_cyc = cyc;
         end
      end
   end

   // ---------------- DUT event monitor ----------------
   int dut_done_cyc = 0, dut_acc_cyc = 0, last_start_cyc = 0;
   int sc[$];
   logic [15:0] sx[$], sy[$];
   always @(negedge clk) begin
      if (rst_n) begin
         if (done) dut_done_cyc = cyc;
         if (cmd_ready && cmd_valid) dut_acc_cyc = cyc;
         if (calc_start) begin
            last_start_cyc = cyc;
            sc.push_back(cyc);
            sx.push_back(calc_x);
            sy.push_back(calc_y);
         end
      end
   end

   // ---------------- phase_calc stub ----------------
   bit         stub_pending = 0;
   int         stub_due = -1, stub_addr = 0, hold_from = -1;
   logic [5:0] stub_idx = '0;
   int         stub_L = 5, block_addr = -1, hold_addr = -1;
   bit         stub_rand_L = 0, stub_rand_idx = 0, stub_spurious = 0, busy_rand = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         stub_pending = 0;
      end else if (calc_start) begin
         stub_addr    = (int'(calc_y) / PITCH) * NC + int'(calc_x) / PITCH;
         stub_pending = 1;
         stub_due     = (stub_addr == block_addr) ? -1 :
                        cyc + (stub_rand_L ? int'($urandom_range(1, 6)) : stub_L);
         stub_idx     = stub_rand_idx ? 6'($urandom) : 6'(3 * stub_addr + 1);
      end else if (stub_pending && calc_valid && cyc == stub_due) begin
         stub_pending = 0;
         if (stub_addr + 1 == hold_addr) hold_from = cyc + 2;
      end else if (done) begin
         stub_pending = 0;
      end
   end

   always @(posedge clk) begin
      #1;
      calc_valid = 1'b0;
      calc_idx   = 6'($urandom);
      if (!rst_n) begin
         calc_busy = 1'b0;
      end else begin
         if (stub_pending && cyc == stub_due) begin
            calc_valid = 1'b1;
            calc_idx   = stub_idx;
         end else if (!stub_pending && stub_spurious && $urandom_range(0, 2) == 0) begin
            calc_valid = 1'b1;
         end
         calc_busy = (hold_from >= 0 && cyc >= hold_from && cyc < hold_from + 3) ||
                     (busy_rand && $urandom_range(0, 3) == 0);
      end
   end

   // ---------------- stimulus ----------------
   bit rd_rand = 0, cal_rand = 0;
   int acc, first_done;
   logic [5:0] v;
   int exp_x [4] = '{0, 1920, 0, 1920};
   int exp_y [4] = '{0, 0, 1920, 1920};
   int tbl_a [4] = '{1, 4, 7, 10};
   int tbl_b [4] = '{1, 4, 7, 8};

   task automatic tick();
      @(posedge clk);
      #1;
      cal_we = 1'b0;
      if (rd_rand) rd_addr = 2'($urandom);
      if (cal_rand && $urandom_range(0, 7) == 0) begin
         cal_we   = 1'b1;
         cal_addr = 2'($urandom);
         cal_data = 6'($urandom);
      end
   endtask

   task automatic send_cmd(input logic [15:0] az, input logic [15:0] el, input logic tx);
      int c0 = m_acc_cnt;
      sc.delete(); sx.delete(); sy.delete();
      cmd_az = az; cmd_el = el; cmd_is_tx = tx; cmd_valid = 1'b1;
      for (int i = 0; i < 300 && m_acc_cnt == c0; i++) tick();
      cmd_valid = 1'b0;
      check("accept_wait", m_acc_cnt - c0, 1);
   endtask

   task automatic wait_done();
      int c0 = m_done_cnt;
      for (int i = 0; i < 2000 && m_done_cnt == c0; i++) tick();
      check("done_wait", m_done_cnt - c0, 1);
   endtask

   task automatic read_tbl(input logic [1:0] a, output logic [5:0] val);
      rd_addr = a;
      tick();
      @(negedge clk);
      val = rd_data;
   endtask

   initial begin
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Baseline: L=5, idx=3*addr+1
      send_cmd(16'd3840, 16'd7680, 1'b1);
      acc = m_acc_cyc;
      wait_done();
      check("A_done_cycle", dut_done_cyc - acc, 29);
      check("A_num_starts", sx.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < sx.size()) begin
            check($sformatf("A_x%0d", i), sx[i], exp_x[i]);
            check($sformatf("A_y%0d", i), sy[i], exp_y[i]);
         end
      end
      check("A_az_held", calc_az, 3840);
      for (int i = 0; i < 4; i++) begin
         read_tbl(2'(i), v);
         check($sformatf("A_tbl%0d", i), v, tbl_a[i]);
         tick();
      end

      // Calibration offset wraps mod 64
      cal_we = 1'b1; cal_addr = 2'd3; cal_data = 6'd62;
      tick();
      send_cmd(16'd3840, 16'd7680, 1'b1);
      wait_done();
      for (int i = 0; i < 4; i++) begin
         read_tbl(2'(i), v);
         check($sformatf("B_tbl%0d", i), v, tbl_b[i]);
         tick();
      end

      // Timeout at addr 2 aborts the scan and keeps later entries
      block_addr = 2;
      send_cmd(16'd1000, 16'd2000, 1'b0);
      wait_done();
      check("C_done_after_wait_entry", dut_done_cyc - (last_start_cyc + 1), 17);
      check("C_err_sticky", err_timeout, 1);
      for (int i = 0; i < 4; i++) begin
         read_tbl(2'(i), v);
         check($sformatf("C_tbl%0d", i), v, tbl_b[i]);
         tick();
      end
      block_addr = -1;
      send_cmd(16'd3840, 16'd7680, 1'b1);
      check("C_err_cleared", err_timeout, 0);
      wait_done();

      // calc_busy held 3 cycles at the addr 1 ISSUE
      hold_addr = 1;
      send_cmd(16'd3840, 16'd7680, 1'b1);
      acc = m_acc_cyc;
      wait_done();
      hold_addr = -1;
      check("D_num_starts", sc.size(), 4);
      if (sc.size() > 1) check("D_start1_cycle", sc[1] - acc, 11);
      check("D_done_cycle", dut_done_cyc - acc, 32);

      // Spurious calc_valid outside WAIT and cmd_valid held through a scan
      stub_spurious = 1;
      send_cmd(16'd3840, 16'd7680, 1'b1);
      cmd_valid = 1'b1;
      wait_done();
      first_done = dut_done_cyc;
      acc = m_acc_cnt;
      for (int i = 0; i < 10 && m_acc_cnt == acc; i++) tick();
      cmd_valid = 1'b0;
      check("E_reaccept_after_done", dut_acc_cyc - first_done, 1);
      wait_done();
      stub_spurious = 0;
      for (int i = 0; i < 4; i++) begin
         read_tbl(2'(i), v);
         check($sformatf("E_tbl%0d", i), v, tbl_b[i]);
         tick();
      end

      // Randomized scans
      stub_rand_L = 1; stub_rand_idx = 1; stub_spurious = 1; busy_rand = 1;
      rd_rand = 1; cal_rand = 1;
      for (int n = 0; n < 14; n++) begin
         block_addr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
         send_cmd(16'($urandom), 16'($urandom), 1'($urandom));
         wait_done();
         repeat ($urandom_range(0, 3)) tick();
      end
      block_addr = -1;
      stub_rand_L = 0; stub_rand_idx = 0; stub_spurious = 0; busy_rand = 0;
      rd_rand = 0; cal_rand = 0;

      // Reset during WAIT of addr 2 clears everything
      send_cmd(16'd3840, 16'd7680, 1'b1);
      for (int i = 0; i < 100 && sc.size() < 3; i++) tick();
      check("G_reached_addr2", sc.size(), 3);
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         read_tbl(2'(i), v);
         check($sformatf("G_tbl%0d", i), v, 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/beam_phase_scheduler.md
# beam_phase_scheduler

Per-element sequencer directly upstream of `phase_calc`. Accepts one beam command (az, el, TX/RX), walks every element of an N_COLS×N_ROWS grid, and drives `phase_calc` once per element with that element's (x, y) offset. It collects each 6-bit `phase_idx` result, adds a per-element calibration offset (mod 64), and stores the final codes in a readable phase table for the shifter-programming logic.

## Interface
- `N_COLS`, 4: grid columns.
- `N_ROWS`, 4: grid rows.
- `PITCH_X`, 16'd1920: column pitch, Q9.7 mm (15.0 mm).
- `PITCH_Y`, 16'd1920: row pitch, Q9.7 mm.
- `TIMEOUT`, 255: maximum WAIT cycles per element.
- ADDR_W (derived) = $clog2(N_COLS*N_ROWS); element addr = row*N_COLS + col.

- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_is_tx` in 1, `cmd_az` in 16, `cmd_el` in 16: Q9.7 deg, unsigned.
- `calc_start` out 1: one-cycle start to `phase_calc`.
- `calc_is_tx` out 1, `calc_x` out 16, `calc_y` out 16, `calc_az` out 16, `calc_el` out 16: `phase_calc` operands (Q9.7).
- `calc_busy` in 1, `calc_valid` in 1, `calc_idx` in 6: from `phase_calc`.
- `cal_we` in 1, `cal_addr` in ADDR_W, `cal_data` in 6: calibration RAM write.
- `rd_addr` in ADDR_W, `rd_data` out 6: table read, registered.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse at end of scan (normal or aborted).
- `err_timeout` out 1: sticky; cleared on next command accept.

## Operation
- Reset: state IDLE; `cmd_ready`=1; `calc_start`, `busy`, `done`, `err_timeout`=0; all calc_* operands = 0; `rd_data`=0; table and cal RAM cleared to 0.
- Command handshake: accept on a rising edge with `cmd_valid && cmd_ready`. On accept, latch is_tx/az/el into calc_* outputs. Clear col, row, x-acc, y-acc and `err_timeout`.
- FSM:
  - IDLE→ISSUE on accept.
  - ISSUE: if `calc_busy`=0, assert `calc_start` for this cycle, then go to WAIT. Otherwise hold with `calc_start`=0.
  - WAIT: cycle counter starts at 0 on entry. `calc_valid`=1 goes to WRITE. Counter reaching TIMEOUT without valid goes to DONE with `err_timeout`=1.
  - WRITE: table[addr] ← (`calc_idx` + cal[addr]) mod 64, 6-bit wrap. `calc_idx` is captured in the WAIT cycle where valid is seen. Then advance: col+1 and x-acc += PITCH_X. At col=N_COLS−1, col=0, x-acc=0, row+1, y-acc += PITCH_Y. Last element goes to DONE, otherwise ISSUE.
  - DONE: `done`=1 for one cycle, then IDLE.
- `calc_x`/`calc_y` equal x-acc/y-acc. They are stable from ISSUE through WRITE. Accumulators only; no multipliers. Accumulators are 16-bit and wrap silently; the integrator keeps (N−1)·pitch below 2^16.
- `calc_valid` outside WAIT is ignored.
- Aborted scan: table entries not yet written keep their prior values.
- Cal write same-edge as WRITE to the same addr: WRITE uses the old cal value. The new value applies to later scans.
- `rd_data` ← table[rd_addr] each edge. A same-edge WRITE to the same addr returns the old value (read-before-write).
- Reset asserted mid-scan: immediate return to reset values, table cleared.

## Timing
- Let L = cycles from the `calc_start` cycle to the `calc_valid` cycle, with L ≥ 1 and `calc_busy`=0.
- Accept edge E0. Cycle 1: ISSUE with `calc_start`. Cycles 2…1+L: WAIT. Cycle 2+L: WRITE. Next element ISSUE at cycle 3+L.
- Per element: L+2 cycles. `done` high in cycle 1 + N·(L+2), with N = N_COLS·N_ROWS. Next accept is possible 1 cycle later.
- Each cycle `calc_busy`=1 in ISSUE adds one cycle.
- Timeout: DONE occurs TIMEOUT+1 cycles after entering WAIT.

## Test plan
- 2×2 grid, PITCH 1920, stub L=5 returning idx=3·addr+1. Command az=3840 (30°), el=7680 (60°), tx=1. Required: calc_(x,y) = (0,0), (1920,0), (0,1920), (1920,1920); table = 1, 4, 7, 10; `done` in cycle 29; calc_az=3840 throughout.
- Same command with cal[3]=62 written beforehand. Required: table[3]=(10+62) mod 64=8; others unchanged.
- TIMEOUT=16; stub withholds valid for addr 2. Required: `done` 17 cycles after WAIT entry; `err_timeout`=1; table[2], table[3] keep prior values. A new accept clears `err_timeout`.
- `calc_busy` held 3 cycles at the addr 1 ISSUE. Required: `calc_start` delayed 3 cycles; `done` 3 cycles later than baseline; `cmd_ready`=0 throughout.
- Spurious `calc_valid` in IDLE/ISSUE, plus a cmd_valid held during a scan. Required: no table write; second command accepted only after `done`.
- `rst_n` low during WAIT of addr 2. Required: all outputs 0 except `cmd_ready`=1; `rd_data` of any addr = 0 after release.
